packet_mux_nway: RTL and testbench
==================================

PACKET_MUX_NWAY -- requirements
Module: packet_mux_nway

Interface
REQ-001 Parameter NUM_CH, default 4: number of input channels; legal range 2..8.
REQ-002 Parameter PRIO, default 0: 0 selects round-robin arbitration, 1 selects fixed priority with channel 0 highest.
REQ-003 Port clk, input, 1: single clock; all logic is in this domain.
REQ-004 Port reset_n, input, 1: asynchronous active-low reset.
REQ-005 Port clear, input, 1: synchronous clear, active high.
REQ-006 Port ch_enable, input, NUM_CH: per-channel arbitration mask; 1 makes the channel eligible.
REQ-007 Port data_i, input, NUM_CH*36: flattened channel data; channel k occupies bits [36k+35:36k].
REQ-008 Port src_rdy_i, input, NUM_CH: per-channel valid.
REQ-009 Port dst_rdy_o, output, NUM_CH: per-channel ready.
REQ-010 Port data_o, output, 36: merged output data.
REQ-011 Port src_rdy_o, output, 1: output valid.
REQ-012 Port dst_rdy_i, input, 1: downstream ready.
REQ-013 Port cur_ch, output, 3: index of the granted channel; meaningful only in BUSY.
REQ-014 Port pkt_count, output, 32: count of packets forwarded.

Function
REQ-015 The word format is fifo36: bit 32 is SOF, bit 33 is EOF, and bits 35:34 are occupancy, passed through unmodified.
REQ-016 A transfer occurs on a cycle where the ready and valid of the same link are both 1.
REQ-017 The state machine has two states, IDLE and BUSY.
REQ-018 In IDLE, src_rdy_o=0 and dst_rdy_o is all zeros.
REQ-019 In IDLE, if any channel k has src_rdy_i[k]=1 and ch_enable[k]=1, the block registers grant=k and enters BUSY on the next edge, giving one cycle of arbitration latency.
REQ-020 PRIO=1: the block grants the lowest eligible index.
REQ-021 PRIO=0: the block grants the first eligible index searching upward from (last_grant+1) mod NUM_CH, wrapping.
REQ-022 After reset, last_grant = NUM_CH-1, so channel 0 is searched first.
REQ-023 In BUSY, data_o, src_rdy_o and dst_rdy_o[grant] are combinational pass-throughs:
- data_o = data_i[grant]
- src_rdy_o = src_rdy_i[grant]
- dst_rdy_o[grant] = dst_rdy_i
- all other dst_rdy_o bits = 0
REQ-024 Once a packet is granted there are zero cycles of data latency and no bubbles inserted.
REQ-025 In BUSY, an output transfer with EOF=1 returns the block to IDLE, sets last_grant=grant and increments pkt_count.
REQ-026 A word with both SOF=1 and EOF=1 is a complete one-word packet.
REQ-027 Deasserting ch_enable[grant] mid-packet does not abort the packet; the mask affects only arbitration in IDLE.
REQ-028 If no channel is eligible in IDLE, the block stays in IDLE indefinitely.
REQ-029 pkt_count wraps from 0xFFFFFFFF to 0.
REQ-030 When NUM_CH is not a power of two, grant never takes a value of NUM_CH or above.
REQ-031 clear=1 forces the following on the next edge, regardless of mid-packet state:
- state to IDLE
- last_grant to NUM_CH-1
- pkt_count to 0
REQ-032 clear has priority over a simultaneous EOF transfer; the counter does not increment on that cycle.

Reset
REQ-033 reset_n=0 asynchronously forces state to IDLE, last_grant to NUM_CH-1, grant to 0 and pkt_count to 0.
REQ-034 While reset_n=0, src_rdy_o=0 and dst_rdy_o is all zeros.
REQ-035 The reset value of cur_ch is 0.
REQ-036 The reset value of data_o is data_i[0], since it is a combinational pass-through of grant 0.
REQ-037 The block accepts arbitration on the first rising edge after reset_n deasserts.

Configuration
REQ-038 Macro PACKET_MUX_NWAY_STATS_EN defined: pkt_count is implemented as specified in REQ-025, REQ-029, REQ-031 and REQ-032.
REQ-039 Macro PACKET_MUX_NWAY_STATS_EN undefined: pkt_count is tied to 32'h0 and no counter logic is synthesised; all other behaviour is identical.

Verification
REQ-040 Scenario, basic pass-through:
- Stimulus: NUM_CH=4, PRIO=0; channels 0 and 2 each present a 3-word packet simultaneously; dst_rdy_i=1.
- Response: channel 0's three words, one idle arbitration cycle, then channel 2's three words; pkt_count=2.
REQ-041 Scenario, round-robin fairness:
- Stimulus: PRIO=0; all 4 channels continuously valid with 1-word packets.
- Response: grant order 0,1,2,3,0,...; 8 packets take 16 cycles.
REQ-042 Scenario, fixed priority:
- Stimulus: PRIO=1; channels 1 and 3 continuously valid.
- Response: only channel 1 is ever granted; dst_rdy_o[3] stays 0.
REQ-043 Scenario, mask and backpressure:
- Stimulus: ch_enable=4'b1110 with channel 0 valid; then enable channel 0 mid-way through a channel 1 packet while dst_rdy_i toggles 1,0,1,0.
- Response: channel 0 is not granted until channel 1's EOF; no word is lost or duplicated; output data is held stable while dst_rdy_i=0.
REQ-044 Scenario, clear and reset mid-packet:
- Stimulus: clear=1 on word 2 of a 5-word packet; later, reset_n=0 asynchronously mid-packet.
- Response: IDLE on the next edge after clear; pkt_count=0; next grant is channel 0; after reset, outputs are 0 immediately without waiting for a clock edge.

Source files
------------

// File: rtl/packet_mux_nway.sv
// N-channel fifo36 packet multiplexer: round-robin (PRIO=0) or fixed-priority (PRIO=1) packet arbitration.
// Define PACKET_MUX_NWAY_STATS_EN to build the forwarded-packet counter behind pkt_count.
module packet_mux_nway #(
    parameter int NUM_CH = 4,
    parameter int PRIO   = 0
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic [NUM_CH-1:0]    ch_enable,
    input  logic [NUM_CH*36-1:0] data_i,
    input  logic [NUM_CH-1:0]    src_rdy_i,
    output logic [NUM_CH-1:0]    dst_rdy_o,
    output logic [35:0]          data_o,
    output logic                 src_rdy_o,
    input  logic                 dst_rdy_i,
    output logic [2:0]           cur_ch,
    output logic [31:0]          pkt_count
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;

    localparam logic [2:0] LAST_CH = 3'(NUM_CH - 1);

    state_t      state_reg;
    logic [2:0]  grant_reg;
    logic [2:0]  last_grant_reg;
    logic [35:0] ch_data [8];
    logic [7:0]  ch_valid;
    logic [7:0]  ch_elig;
    logic [2:0]  grant_next;
    logic        grant_found;
    logic        busy;
    logic        eof_xfer;
    int          cand;

    assign busy = (state_reg == BUSY);

    // Channel views are padded to eight entries so the 3-bit grant indexes them without range issues.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_ch
            if (gi < NUM_CH) begin : g_used
                assign ch_data[gi]   = data_i[36*gi +: 36];
                assign ch_valid[gi]  = src_rdy_i[gi];
                assign ch_elig[gi]   = src_rdy_i[gi] & ch_enable[gi];
                assign dst_rdy_o[gi] = busy && (grant_reg == 3'(gi)) && dst_rdy_i;
            end else begin : g_unused
                assign ch_data[gi]  = '0;
                assign ch_valid[gi] = 1'b0;
                assign ch_elig[gi]  = 1'b0;
            end
        end
    endgenerate

    assign data_o    = ch_data[grant_reg];
    assign src_rdy_o = busy && ch_valid[grant_reg];
    assign cur_ch    = grant_reg;
    assign eof_xfer  = src_rdy_o && dst_rdy_i && data_o[33];

    // Candidate search order starts one past the last winner; a single subtraction keeps it in range.
    always_comb begin
        grant_next  = 3'd0;
        grant_found = 1'b0;
        cand        = 0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (PRIO != 0) begin
                cand = i;
            end else begin
                cand = int'(last_grant_reg) + 1 + i;
                if (cand >= NUM_CH) begin
                    cand = cand - NUM_CH;
                end
            end
            if (!grant_found && ch_elig[3'(cand)]) begin
                grant_found = 1'b1;
                grant_next  = 3'(cand);
            end
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg      <= IDLE;
            grant_reg      <= 3'd0;
            last_grant_reg <= LAST_CH;
        end else if (clear) begin
            state_reg      <= IDLE;
            last_grant_reg <= LAST_CH;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (grant_found) begin
                        grant_reg <= grant_next;
                        state_reg <= BUSY;
                    end
                end
                BUSY: begin
                    if (eof_xfer) begin
                        state_reg      <= IDLE;
                        last_grant_reg <= grant_reg;
                    end
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

`ifdef PACKET_MUX_NWAY_STATS_EN
    logic [31:0] pkt_count_reg;
    logic [31:0] pkt_count_next;

    // Clear wins over a coincident EOF, so the last packet of a cleared run is not counted.
    always_comb begin
        pkt_count_next = pkt_count_reg;
        if (clear) begin
            pkt_count_next = 32'h0;
        end else if (eof_xfer) begin
            pkt_count_next = pkt_count_reg + 32'h1;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pkt_count_reg <= 32'h0;
        end else begin
            pkt_count_reg <= pkt_count_next;
        end
    end

    assign pkt_count = pkt_count_reg;
`else
    assign pkt_count = 32'h0;
`endif

endmodule

// File: tb/tb_packet_mux_nway.sv
// Bench for packet_mux_nway: round-robin and fixed-priority instances share stimulus; a
// behavioural model feeds per-instance expectation queues that a monitor drains each cycle.
module tb_packet_mux_nway;
    localparam int NCH = 4;
`ifdef PACKET_MUX_NWAY_STATS_EN
    localparam bit STATS = 1'b1;
`else
    localparam bit STATS = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             reset_n = 1'b1;
    logic             clear = 1'b0;
    logic             dst_rdy_i = 1'b0;
    logic [NCH-1:0]   ch_enable = '0;
    logic [NCH-1:0]   src_rdy_i = '0;
    logic [NCH*36-1:0] data_i = '0;

    logic [NCH-1:0] dst_rdy_o [2];
    logic [35:0]    data_o [2];
    logic           src_rdy_o [2];
    logic [2:0]     cur_ch [2];
    logic [31:0]    pkt_count [2];

    packet_mux_nway #(.NUM_CH(NCH), .PRIO(0)) u_rr (
        .clk(clk), .reset_n(reset_n), .clear(clear), .ch_enable(ch_enable),
        .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o[0]),
        .data_o(data_o[0]), .src_rdy_o(src_rdy_o[0]), .dst_rdy_i(dst_rdy_i),
        .cur_ch(cur_ch[0]), .pkt_count(pkt_count[0])
    );

    packet_mux_nway #(.NUM_CH(NCH), .PRIO(1)) u_fp (
        .clk(clk), .reset_n(reset_n), .clear(clear), .ch_enable(ch_enable),
        .data_i(data_i), .src_rdy_i(src_rdy_i), .dst_rdy_o(dst_rdy_o[1]),
        .data_o(data_o[1]), .src_rdy_o(src_rdy_o[1]), .dst_rdy_i(dst_rdy_i),
        .cur_ch(cur_ch[1]), .pkt_count(pkt_count[1])
    );

    always #5 clk = ~clk;

    typedef struct {
        logic           busy;
        logic           in_reset;
        logic           src_rdy;
        logic [NCH-1:0] dst_rdy;
        logic [35:0]    data;
        logic [2:0]     ch;
        logic [31:0]    cnt;
    } exp_t;

    exp_t exp_q0[$];
    exp_t exp_q1[$];
    int   n_checks = 0;
    int   n_pass = 0;

    task automatic chk(input string what, input int u, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act === req) n_pass++;
        else $display("FAIL %s[%s] t=%0t got=%h want=%h", what, (u == 1) ? "fp" : "rr", $time, act, req);
    endtask

    // Reference model: packet-level view (idle or owning a channel), one step per clock.
    bit          m_busy [2];
    int          m_grant [2];
    int          m_last [2];
    logic [31:0] m_cnt [2];

    task automatic model_step(input int u);
        exp_t           e;
        int             g;
        int             cand;
        logic [NCH-1:0] elig;
        if (!reset_n) begin
            m_busy[u] = 1'b0; m_grant[u] = 0; m_last[u] = NCH - 1; m_cnt[u] = 32'h0;
        end
        g = m_grant[u];
        e.in_reset = !reset_n;
        e.busy     = m_busy[u];
        e.data     = data_i[36*g +: 36];
        e.ch       = 3'(g);
        e.cnt      = STATS ? m_cnt[u] : 32'h0;
        e.src_rdy  = m_busy[u] && src_rdy_i[g];
        e.dst_rdy  = '0;
        if (m_busy[u]) e.dst_rdy[g] = dst_rdy_i;
        if (u == 0) exp_q0.push_back(e); else exp_q1.push_back(e);
        if (!reset_n) return;
        if (clear) begin
            m_busy[u] = 1'b0; m_last[u] = NCH - 1; m_cnt[u] = 32'h0;
        end else if (m_busy[u]) begin
            if (e.src_rdy && dst_rdy_i && e.data[33]) begin
                m_busy[u] = 1'b0; m_last[u] = g; m_cnt[u] = m_cnt[u] + 32'h1;
            end
        end else begin
            elig = src_rdy_i & ch_enable;
            for (int i = 0; i < NCH; i++) begin
                cand = (u == 1) ? i : (m_last[u] + 1 + i) % NCH;
                if (elig[cand]) begin
                    m_grant[u] = cand; m_busy[u] = 1'b1;
                    break;
                end
            end
        end
    endtask

    always @(negedge clk) begin
        model_step(0);
        model_step(1);
    end

    task automatic compare(input int u, input exp_t e);
        chk("src_rdy_o", u, 64'(src_rdy_o[u]), 64'(e.src_rdy));
        chk("dst_rdy_o", u, 64'(dst_rdy_o[u]), 64'(e.dst_rdy));
        chk("pkt_count", u, 64'(pkt_count[u]), 64'(e.cnt));
        if (e.busy || e.in_reset) begin
            chk("data_o", u, 64'(data_o[u]), 64'(e.data));
            chk("cur_ch", u, 64'(cur_ch[u]), 64'(e.ch));
        end
    endtask

    initial begin
        forever begin
            @(negedge clk);
            #1;
            while (exp_q0.size() > 0) compare(0, exp_q0.pop_front());
            while (exp_q1.size() > 0) compare(1, exp_q1.pop_front());
        end
    end

    // Per-channel packet sources; they advance on the round-robin instance's handshake.
    logic [35:0] src_q [NCH][$];
    int xfer_cnt, fp_ch1_cnt, fp_ch3_rdy;

    task automatic apply_sources();
        for (int k = 0; k < NCH; k++) begin
            src_rdy_i[k] = (src_q[k].size() > 0);
            data_i[36*k +: 36] = (src_q[k].size() > 0) ? src_q[k][0] : 36'h0;
        end
    endtask

    task automatic tick();
        logic [NCH-1:0] took;
        @(negedge clk);
        took = src_rdy_i & dst_rdy_o[0];
        if (src_rdy_o[0] && dst_rdy_i) xfer_cnt++;
        if (dst_rdy_o[1][3]) fp_ch3_rdy++;
        if (dst_rdy_o[1][1] && src_rdy_i[1]) fp_ch1_cnt++;
        @(posedge clk);
        #1;
        for (int k = 0; k < NCH; k++)
            if (took[k] && src_q[k].size() > 0) void'(src_q[k].pop_front());
        apply_sources();
    endtask

    task automatic push_pkt(input int ch, input int len, input logic [31:0] tag);
        for (int i = 0; i < len; i++)
            src_q[ch].push_back({2'($urandom_range(3)), 1'(i == len - 1), 1'(i == 0), tag + 32'(i)});
    endtask

    task automatic flush_and_clear();
        for (int k = 0; k < NCH; k++) src_q[k].delete();
        apply_sources();
        clear = 1'b1;
        tick();
        clear = 1'b0;
    endtask

    task automatic tick_rand();
        @(posedge clk);
        #1;
        src_rdy_i = 4'($urandom);
        ch_enable = ($urandom_range(3) == 0) ? 4'($urandom) : 4'hF;
        dst_rdy_i = ($urandom_range(3) != 0);
        clear     = ($urandom_range(40) == 0);
        for (int k = 0; k < NCH; k++)
            data_i[36*k +: 36] = {2'($urandom), 1'($urandom_range(2) == 0), 1'($urandom), 32'($urandom)};
    endtask

    initial begin
        for (int k = 0; k < NCH; k++) data_i[36*k +: 36] = {4'($urandom), 32'($urandom)};
        #2 reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        reset_n = 1'b1; dst_rdy_i = 1'b1; ch_enable = 4'hF;

        // Two simultaneous 3-word packets on channels 0 and 2
        push_pkt(0, 3, 32'h100); push_pkt(2, 3, 32'h200); apply_sources();
        repeat (12) tick();

        // Round-robin fairness: all channels continuously valid with single-word packets
        flush_and_clear();
        for (int k = 0; k < NCH; k++) for (int p = 0; p < 4; p++) push_pkt(k, 1, 32'h1000 * (k + 1) + 32'(p));
        apply_sources();
        xfer_cnt = 0;
        repeat (16) tick();
        chk("rr_8pkts_16cyc", 0, 64'(xfer_cnt), 64'd8);

        // Fixed priority: channels 1 and 3 continuously valid
        flush_and_clear();
        for (int p = 0; p < 12; p++) begin push_pkt(1, 1, 32'h3100 + 32'(p)); push_pkt(3, 1, 32'h3300 + 32'(p)); end
        apply_sources();
        fp_ch1_cnt = 0; fp_ch3_rdy = 0;
        repeat (20) tick();
        chk("fp_ch1_grants", 1, 64'(fp_ch1_cnt), 64'd10);
        chk("fp_ch3_ready", 1, 64'(fp_ch3_rdy), 64'd0);

        // Mask and backpressure: channel 0 enabled mid-way through a channel 1 packet
        flush_and_clear();
        ch_enable = 4'b1110;
        push_pkt(0, 2, 32'h4000); push_pkt(1, 4, 32'h4100); apply_sources();
        for (int i = 0; i < 18; i++) begin
            tick();
            dst_rdy_i = ~dst_rdy_i;
            if (i == 3) ch_enable = 4'hF;
        end
        dst_rdy_i = 1'b1;

        // Clear on word 2 of a 5-word packet, then an async reset mid-packet
        flush_and_clear();
        push_pkt(2, 5, 32'h5200); apply_sources();
        tick(); tick();
        clear = 1'b1; push_pkt(0, 2, 32'h5000); apply_sources();
        tick();
        clear = 1'b0;
        repeat (10) tick();
        push_pkt(3, 4, 32'h5300); apply_sources();
        tick(); tick();
        #2 reset_n = 1'b0;
        #1;
        chk("async_rst_src_rdy", 0, 64'(src_rdy_o[0]), 64'd0);
        chk("async_rst_dst_rdy", 0, 64'(dst_rdy_o[0]), 64'd0);
        chk("async_rst_dst_rdy", 1, 64'(dst_rdy_o[1]), 64'd0);
        tick(); tick();
        reset_n = 1'b1;
        repeat (8) tick();

        // Randomised traffic
        flush_and_clear();
        repeat (600) tick_rand();
        clear = 1'b0;
        @(negedge clk);
        #3;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
